alu_pipeline_hs: RTL and testbench

ALU_PIPELINE_HS -- requirements
Module: alu_pipeline_hs

---
 rtl/alu_pipeline_hs.sv | 168 ++++++++++++++++
 tb/tb_alu_pipeline_hs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipeline_hs.sv
// alu_pipeline_hs: two-stage valid/ready ALU with an iterative shift-add multiplier in stage 1.
// Revision: 1.0
`default_nettype none

module alu_pipeline_hs #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   mul_state_t         mul_state;
   logic               s1_valid;
   logic [WIDTH-1:0]   s1_a;
   logic [WIDTH-1:0]   s1_b;
   logic [3:0]         s1_op;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc;

   logic in_is_mul;
   logic s1_is_mul;
   logic s1_fin;
   logic s2_load;
   logic move;
   logic accept;

   assign in_is_mul = MUL_EN && (op == OP_MUL);
   assign s1_is_mul = MUL_EN && (s1_op == OP_MUL);
   assign s1_fin    = s1_valid && (!s1_is_mul || (mul_state == DONE));
   assign s2_load   = !out_valid || out_ready;
   assign move      = s1_fin && s2_load;
   assign in_ready  = !s1_valid || move;
   assign accept    = in_valid && in_ready;

   // Stage 1: operand capture and multiplier sequencing. BUSY blocks intake, so it never races accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_op     <= '0;
         cnt       <= '0;
         acc       <= '0;
         mul_state <= IDLE;
      end else if (mul_state == BUSY) begin
         acc <= acc + (s1_b[cnt] ? ({{WIDTH{1'b0}}, s1_a} << cnt) : '0);
         if (cnt == CNT_LAST) begin
            cnt       <= '0;
            mul_state <= DONE;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else if (accept) begin
         s1_valid  <= 1'b1;
         s1_a      <= a;
         s1_b      <= b;
         s1_op     <= op;
         cnt       <= '0;
         acc       <= '0;
         mul_state <= in_is_mul ? BUSY : IDLE;
      end else if (move) begin
         s1_valid  <= 1'b0;
         mul_state <= IDLE;
      end
   end

   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;

   assign add_full = {1'b0, s1_a} + {1'b0, s1_b};
   assign sub_full = {1'b0, s1_a} - {1'b0, s1_b};
   assign shamt    = s1_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (s1_op)
         OP_ADD: begin
            alu_res = add_full[WIDTH-1:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (alu_res[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_full[WIDTH-1:0];
            alu_c   = sub_full[WIDTH];
            alu_v   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (alu_res[WIDTH-1] != s1_a[WIDTH-1]);
         end
         OP_AND:  alu_res = s1_a & s1_b;
         OP_OR:   alu_res = s1_a | s1_b;
         OP_XOR:  alu_res = s1_a ^ s1_b;
         OP_SLL:  alu_res = s1_a << shamt;
         OP_SRL:  alu_res = s1_a >> shamt;
         OP_SRA:  alu_res = $signed(s1_a) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
         OP_MUL: begin
            if (MUL_EN) begin
               alu_res = acc[WIDTH-1:0];
               alu_v   = |acc[2*WIDTH-1:WIDTH];
            end
         end
         default: alu_res = '0;
      endcase
   end

   // Stage 2: only reloads when empty or drained, so a stalled result stays bit-stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_fin;
         if (s1_fin) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            negative <= alu_res[WIDTH-1];
            carry    <= alu_c;
            overflow <= alu_v;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipeline_hs.sv
// tb_alu_pipeline_hs: directed vector table, handshake corner sequences and a randomized scoreboard run.
`default_nettype none

module tb_alu_pipeline_hs;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [3:0]    op = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          zero, negative, carry, overflow;

   alu_pipeline_hs #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   flags;   // {zero, negative, carry, overflow}
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   op;
      logic [W-1:0] res;
      logic [3:0]   flags;
   } vec_t;

   function automatic logic [3:0] cur_flags();
      return {zero, negative, carry, overflow};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: integer arithmetic straight from the opcode definitions.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] iop);
      exp_t   e;
      int     ua = int'(ia);
      int     ub = int'(ib);
      int     sa = int'($signed(ia));
      int     sb = int'($signed(ib));
      int     sh = int'(ib[3:0]);
      int     t = 0;
      longint p;
      logic   c = 1'b0;
      logic   v = 1'b0;
      case (iop)
         4'd0: begin t = ua + ub; c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
         4'd1: begin t = ua - ub; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
         4'd2: t = ua & ub;
         4'd3: t = ua | ub;
         4'd4: t = ua ^ ub;
         4'd5: t = ua << sh;
         4'd6: t = ua >> sh;
         4'd7: t = sa >>> sh;
         4'd8: t = (sa < sb) ? 1 : 0;
         4'd9: t = (ua < ub) ? 1 : 0;
         4'd10: begin
            p = longint'(ua) * longint'(ub);
            t = int'(p % 65536);
            v = (p > 65535);
         end
         default: t = 0;
      endcase
      e.res   = t[W-1:0];
      e.flags = {(e.res == '0), e.res[W-1], c, v};
      return e;
   endfunction

   // Issue one op into an idle pipeline with out_ready high, then check latency, intake blocking and output.
   task automatic run_one(input string tag, input vec_t v);
      int lat = 0;
      int lo = 0;
      int exp_lat = (v.op == 4'b1010) ? 17 : 1;
      int exp_lo = (v.op == 4'b1010) ? 16 : 0;
      int guard = 0;
      in_valid = 1'b1; a = v.a; b = v.b; op = v.op; out_ready = 1'b1;
      #1;
      while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
      chk({tag, "_accept"}, 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         if (!in_ready) lo++;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_ready_low"}, 64'(lo), 64'(exp_lo));
      chk({tag, "_result"}, 64'(result), 64'(v.res));
      chk({tag, "_flags"}, 64'(cur_flags()), 64'(v.flags));
      @(posedge clk); #1;
   endtask

   vec_t vecs[14];
   exp_t q[$];

   initial begin
      vecs[0]  = '{16'h7FFF, 16'h0001, 4'h0, 16'h8000, 4'b0101};
      vecs[1]  = '{16'h0003, 16'h0005, 4'h1, 16'hFFFE, 4'b0110};
      vecs[2]  = '{16'hFFFF, 16'h0001, 4'h8, 16'h0001, 4'b0000};
      vecs[3]  = '{16'hFFFF, 16'h0001, 4'h9, 16'h0000, 4'b1000};
      vecs[4]  = '{16'h8000, 16'h0013, 4'h7, 16'hF000, 4'b0100};
      vecs[5]  = '{16'h1234, 16'h5678, 4'hF, 16'h0000, 4'b1000};
      vecs[6]  = '{16'h0100, 16'h0100, 4'hA, 16'h0000, 4'b1001};
      vecs[7]  = '{16'hFFFF, 16'h0001, 4'h0, 16'h0000, 4'b1010};
      vecs[8]  = '{16'hF0F0, 16'hFF00, 4'h2, 16'hF000, 4'b0100};
      vecs[9]  = '{16'hAAAA, 16'hAAAA, 4'h4, 16'h0000, 4'b1000};
      vecs[10] = '{16'h0001, 16'h000F, 4'h5, 16'h8000, 4'b0100};
      vecs[11] = '{16'h8000, 16'h001F, 4'h6, 16'h0001, 4'b0000};
      vecs[12] = '{16'h8000, 16'h0001, 4'h1, 16'h7FFF, 4'b0001};
      vecs[13] = '{16'h00FF, 16'h0101, 4'hA, 16'hFFFF, 4'b0100};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_result", 64'(result), 64'(0));
      chk("rst_flags", 64'(cur_flags()), 64'(0));
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) run_one($sformatf("vec%0d", i), vecs[i]);

      // Backpressure: 1+1, 2+2, 3+3 with the consumer stalled for five cycles
      begin
         logic [W-1:0] got[$];
         int guard = 0;
         out_ready = 1'b0; op = 4'h0;
         in_valid = 1'b1; a = 16'd1; b = 16'd1;
         @(posedge clk); #1;
         a = 16'd2; b = 16'd2;
         @(posedge clk); #1;
         a = 16'd3; b = 16'd3;
         #1;
         for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall%0d_valid", c), 64'(out_valid), 64'(1));
            chk($sformatf("stall%0d_result", c), 64'(result), 64'(2));
            chk($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'(0));
            @(posedge clk); #2;
         end
         out_ready = 1'b1;
         #1;
         while (got.size() < 3 && guard < 20) begin
            logic took;
            if (out_valid) got.push_back(result);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            if (took) in_valid = 1'b0;
            guard++;
         end
         chk("stall_count", 64'(got.size()), 64'(3));
         for (int i = 0; i < got.size() && i < 3; i++)
            chk($sformatf("stall_order%0d", i), 64'(got[i]), 64'((i + 1) * 2));
         in_valid = 1'b0;
         @(posedge clk); #1;
         chk("stall_drained", 64'(out_valid), 64'(0));
      end

      // Reset while a MUL iterates behind a stalled result
      begin
         int seen = 0;
         out_ready = 1'b0;
         in_valid = 1'b1; op = 4'h0; a = 16'd5; b = 16'd6;
         @(posedge clk); #1;
         op = 4'hA; a = 16'd3; b = 16'd4;
         @(posedge clk); #1;
         in_valid = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk("pre_rst_valid", 64'(out_valid), 64'(1));
         chk("pre_rst_in_ready", 64'(in_ready), 64'(0));
         #2 rst_n = 1'b0;
         #1;
         chk("mid_rst_valid", 64'(out_valid), 64'(0));
         chk("mid_rst_result", 64'(result), 64'(0));
         @(posedge clk); #1;
         rst_n = 1'b1;
         out_ready = 1'b1;
         #1;
         chk("post_rst_in_ready", 64'(in_ready), 64'(1));
         for (int c = 0; c < 30; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
         end
         chk("post_rst_stale", 64'(seen), 64'(0));
      end
      run_one("post_rst_add", '{16'h0001, 16'h0002, 4'h0, 16'h0003, 4'b0000});

      // Randomized traffic against the reference model
      begin
         logic         took_prev = 1'b0;
         logic         stalled = 1'b0;
         logic [W-1:0] held_res = '0;
         logic [3:0]   held_flags = '0;
         exp_t         e;
         int           guard = 0;
         for (int cyc = 0; cyc < 800 + 100; cyc++) begin
            @(posedge clk); #1;
            if (stalled) begin
               chk("rand_hold_valid", 64'(out_valid), 64'(1));
               chk("rand_hold_data", 64'({held_res, held_flags}), 64'({result, cur_flags()}));
            end
            if (cyc < 800) begin
               if (!in_valid || took_prev) begin
                  in_valid = ($urandom_range(0, 3) != 0);
                  op = 4'($urandom_range(0, 15));
                  if (op == 4'hA && $urandom_range(0, 3) != 0) op = 4'h0;
                  a = 16'($urandom);
                  b = 16'($urandom);
                  if ($urandom_range(0, 7) == 0) a = 16'h8000;
                  if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
               end
               out_ready = ($urandom_range(0, 3) != 0);
            end else begin
               in_valid = 1'b0;
               out_ready = 1'b1;
            end
            #1;
            took_prev = in_valid && in_ready;
            if (took_prev) q.push_back(model(a, b, op));
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("rand_spurious", 64'(1), 64'(0));
               end else begin
                  e = q.pop_front();
                  chk("rand_result", 64'(result), 64'(e.res));
                  chk("rand_flags", 64'(cur_flags()), 64'(e.flags));
               end
            end
            stalled = out_valid && !out_ready;
            held_res = result;
            held_flags = cur_flags();
            guard++;
         end
         chk("rand_drain", 64'(q.size()), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
